cond_logic: RTL and testbench

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_logic.sv | 139 +++++++++++++
 tb/tb_cond_logic.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// cond_logic: conditional-execution unit for an ARM-style pipeline stage.
//
// Evaluates the instruction condition field against the architectural NZCV
// register and gates the decoder write requests with the result. Flags are
// loaded from the ALU only by executed, accepted instructions. A saturating
// counter records how many accepted instructions failed their condition.
//
// Parameters:
//   SKIPW      width of the skipped-instruction counter
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous active-low reset
//   Valid      an instruction is presented this cycle
//   Stall      freeze: no state update, write strobes forced low
//   Cond       condition field of the presented instruction
//   ALUFlags   ALU result flags, [3]=N [2]=Z [1]=C [0]=V
//   FlagW      flag write enables, [1] -> N,Z and [0] -> C,V
//   PCS        decoder requests a PC write
//   RegW       decoder requests a register write
//   MemW       decoder requests a memory write
//   NoWrite    compare/test instruction: blocks the register write
//   PCSrc      gated PC write strobe
//   RegWrite   gated register write strobe
//   MemWrite   gated memory write strobe
//   CondEx     combinational condition result for the presented instruction
//   CondExQ    CondEx captured at the last accepted instruction
//   Flags      architectural NZCV register, same bit order as ALUFlags
//   SkipCount  saturating count of accepted instructions that failed Cond

module cond_logic #(
    parameter int unsigned SKIPW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid,
    input  logic             Stall,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic             CondExQ,
    output logic [3:0]       Flags,
    output logic [SKIPW-1:0] SkipCount
);

    logic [3:0]       flags_q, flags_d;
    logic             condexq_q, condexq_d;
    logic [SKIPW-1:0] skip_q, skip_d;

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ex;
    logic accept;
    logic exec;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition is tested against the registered flags, so an instruction that
    // both tests and sets flags sees the values from before its own update.
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign accept = Valid & ~Stall;
    assign exec   = accept & cond_ex;

    // Write strobes are purely combinational; Stall kills them via accept.
    assign PCSrc    = exec & PCS;
    assign RegWrite = exec & RegW & ~NoWrite;
    assign MemWrite = exec & MemW;
    assign CondEx   = cond_ex;

    always_comb begin
        flags_d   = flags_q;
        condexq_d = condexq_q;
        skip_d    = skip_q;

        if (exec && FlagW[1]) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (exec && FlagW[0]) begin
            flags_d[1:0] = ALUFlags[1:0];
        end

        if (accept) begin
            condexq_d = cond_ex;
        end

        // Saturate instead of wrapping once the counter is all ones.
        if (accept && !cond_ex && (skip_q != {SKIPW{1'b1}})) begin
            skip_d = skip_q + SKIPW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q   <= 4'b0000;
            condexq_q <= 1'b0;
            skip_q    <= '0;
        end else begin
            flags_q   <= flags_d;
            condexq_q <= condexq_d;
            skip_q    <= skip_d;
        end
    end

    assign Flags     = flags_q;
    assign CondExQ   = condexq_q;
    assign SkipCount = skip_q;

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: a default-width instance and a SKIPW=2
// instance share all inputs. The stimulus process predicts each cycle's
// outputs from a reference model and queues them; a monitor on the falling
// edge pops and compares.

module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic       Valid, Stall;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite;

    logic       PCSrc8, RegWrite8, MemWrite8, CondEx8, CondExQ8;
    logic [3:0] Flags8;
    logic [7:0] Skip8;
    logic       PCSrc2, RegWrite2, MemWrite2, CondEx2, CondExQ2;
    logic [3:0] Flags2;
    logic [1:0] Skip2;

    cond_logic dut8 (
        .clk(clk), .reset(reset), .Valid(Valid), .Stall(Stall), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .PCSrc(PCSrc8), .RegWrite(RegWrite8), .MemWrite(MemWrite8),
        .CondEx(CondEx8), .CondExQ(CondExQ8), .Flags(Flags8), .SkipCount(Skip8)
    );

    cond_logic #(.SKIPW(2)) dut2 (
        .clk(clk), .reset(reset), .Valid(Valid), .Stall(Stall), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .PCSrc(PCSrc2), .RegWrite(RegWrite2), .MemWrite(MemWrite2),
        .CondEx(CondEx2), .CondExQ(CondExQ2), .Flags(Flags2), .SkipCount(Skip2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cx;
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic [3:0] flags;
        logic       cxq;
        int         skip8;
        int         skip2;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model state: value the registers hold after the most recent edge.
    logic [3:0] m_flags;
    logic       m_cxq;
    int         m_skip8, m_skip2;

    // Conditions come in complementary pairs: even code tests a predicate,
    // odd code tests its negation; 14 and 15 always execute.
    function automatic logic model_cond(input logic [3:0] f, input logic [3:0] c);
        bit n, z, cy, v, p;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c >= 4'd14) return 1'b1;
        case (c >> 1)
            0: p = z;
            1: p = cy;
            2: p = n;
            3: p = v;
            4: p = cy && !z;
            5: p = (n == v);
            default: p = !z && (n == v);
        endcase
        return (c % 2 == 0) ? p : !p;
    endfunction

    task automatic step(input logic vld, input logic stl, input logic [3:0] cnd,
                        input logic [3:0] aluf, input logic [1:0] fw, input logic pcs,
                        input logic rw, input logic mw, input logic nw);
        exp_t  e;
        logic  cx, acc;
        @(posedge clk);
        #1;
        Valid = vld; Stall = stl; Cond = cnd; ALUFlags = aluf; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        cx  = model_cond(m_flags, cnd);
        acc = vld && !stl;
        e.cx       = cx;
        e.pcsrc    = acc && cx && pcs;
        e.regwrite = acc && cx && rw && !nw;
        e.memwrite = acc && cx && mw;
        e.flags    = m_flags;
        e.cxq      = m_cxq;
        e.skip8    = m_skip8;
        e.skip2    = m_skip2;
        exp_q.push_back(e);
        if (reset && acc) begin
            m_cxq = cx;
            if (cx) begin
                if (fw[1]) m_flags[3:2] = aluf[3:2];
                if (fw[0]) m_flags[1:0] = aluf[1:0];
            end else begin
                if (m_skip8 < 255) m_skip8++;
                if (m_skip2 < 3) m_skip2++;
            end
        end
    endtask

    task automatic model_clear();
        m_flags = 4'b0000;
        m_cxq   = 1'b0;
        m_skip8 = 0;
        m_skip2 = 0;
    endtask

    // Asynchronous reset mid-cycle; flags must clear before the next edge.
    // One instruction is presented while reset is held to check that the
    // strobes still work and its flag write is discarded.
    task automatic do_reset();
        @(posedge clk);
        #1 Valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_clear_flags8", Flags8, 0);
        check("async_clear_flags2", Flags2, 0);
        check("async_clear_skip8", Skip8, 0);
        model_clear();
        step(1, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
        @(posedge clk);
        #1 Valid = 1'b0;
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("condex8", CondEx8, e.cx);
            check("pcsrc8", PCSrc8, e.pcsrc);
            check("regwrite8", RegWrite8, e.regwrite);
            check("memwrite8", MemWrite8, e.memwrite);
            check("flags8", Flags8, e.flags);
            check("condexq8", CondExQ8, e.cxq);
            check("skip8", Skip8, e.skip8);
            check("condex2", CondEx2, e.cx);
            check("regwrite2", RegWrite2, e.regwrite);
            check("flags2", Flags2, e.flags);
            check("skip2", Skip2, e.skip2);
        end
    end

    initial begin
        int wait_cycles;
        reset = 1'b0;
        Valid = 0; Stall = 0; Cond = 0; ALUFlags = 0; FlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
        model_clear();
        #1;
        check("reset_flags", Flags8, 0);
        check("reset_condexq", CondExQ8, 0);
        check("reset_skip", Skip8, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // EQ with Z clear: skipped, no register write, count goes to 1.
        step(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0);
        // CMP-like AL: flags set, register write blocked.
        step(1, 0, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1);
        // EQ now sees Z=1 from the previous instruction.
        step(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0);
        // GE/LE directed cases.
        step(1, 0, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 1);
        step(1, 0, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0);
        step(1, 0, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 1);
        step(1, 0, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0);
        step(1, 0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 1);
        step(1, 0, 4'b1101, 4'b0000, 2'b00, 1, 0, 1, 0);
        // NE with partial flag write: tests old flags, only N,Z change.
        step(1, 0, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 1);
        step(1, 0, 4'b0001, 4'b0100, 2'b10, 0, 1, 0, 0);
        step(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
        // Flags all set, then reset between edges.
        step(1, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 1);
        step(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
        do_reset();
        // Five failed EQs: narrow counter saturates at 3.
        repeat (5) step(1, 0, 4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0);
        // Stalled instructions: no strobes, no count or flag change.
        step(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
        step(1, 1, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0);
        step(0, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
        step(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        step(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
